// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and helpers for the shift issue queue
package shift_pkg;

    localparam int SHIFT_W = 8;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ROL = 2'b10,
        SH_ROR = 2'b11
    } shift_fn_t;

    typedef struct packed {
        logic [SHIFT_W-1:0] data;
        logic [2:0]         sc;
        shift_fn_t          fn;
    } shift_cmd_t;

    typedef enum logic {
        RES_EMPTY = 1'b0,
        RES_FULL  = 1'b1
    } res_state_t;

    // The shifter only produces a meaningful carry for logical shifts by a non-zero count.
    function automatic logic carry_defined(shift_cmd_t cmd);
        return (cmd.fn == SH_LSL || cmd.fn == SH_LSR) && (cmd.sc != 3'd0);
    endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// rtl/shift_cmd_fifo.sv - DEPTH-entry FIFO of shift commands with head/count outputs
module shift_cmd_fifo
    import shift_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  shift_cmd_t             push_cmd,
    input  logic                   pop,
    output shift_cmd_t             head_cmd,
    output logic                   head_valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("shift_cmd_fifo: DEPTH must be a power of two and at least 2");
    end

    shift_cmd_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_cmd;
        end
    end

    assign head_cmd   = mem_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign full       = (count_q == CW'(DEPTH));
    assign count      = count_q;

endmodule

// File: rtl/shift_issue_queue.sv
// rtl/shift_issue_queue.sv - command queue and result register around a combinational shifter
// Optional feature: define SHIFT_Q_BYPASS_EN to let commands skip the empty FIFO.
module shift_issue_queue
    import shift_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic [2:0]             in_sc,
    input  logic [1:0]             in_fn,
    output logic [7:0]             sh_data,
    output logic [2:0]             sh_sc,
    output logic [1:0]             sh_fn,
    input  logic [7:0]             sh_out,
    input  logic                   sh_c,
    input  logic                   sh_z,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [7:0]             res_data,
    output logic                   res_c,
    output logic                   res_z,
    output logic [$clog2(DEPTH):0] q_count
);

    shift_cmd_t in_cmd;
    shift_cmd_t head_cmd;
    shift_cmd_t drive_cmd;
    logic       head_valid;
    logic       fifo_full;
    logic       fifo_push;
    logic       fifo_pop;
    logic       src_valid;
    logic       capture;
    logic       bypass_cap;

    res_state_t res_state_q, res_state_d;
    logic [7:0] res_data_q, res_data_d;
    logic       res_c_q, res_c_d;
    logic       res_z_q, res_z_d;

    always_comb begin
        in_cmd.data = in_data;
        in_cmd.sc   = in_sc;
        in_cmd.fn   = shift_fn_t'(in_fn);
    end

    shift_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_cmd   (in_cmd),
        .pop        (fifo_pop),
        .head_cmd   (head_cmd),
        .head_valid (head_valid),
        .full       (fifo_full),
        .count      (q_count)
    );

    assign in_ready = !fifo_full;

    always_comb begin
`ifdef SHIFT_Q_BYPASS_EN
        drive_cmd = head_valid ? head_cmd : in_cmd;
        src_valid = head_valid || in_valid;
`else
        drive_cmd = head_valid ? head_cmd : '0;
        src_valid = head_valid;
`endif
        capture    = src_valid && (res_state_q == RES_EMPTY || res_ready);
        // A capture with an empty FIFO can only be an incoming command taking the bypass.
        bypass_cap = capture && !head_valid;
        fifo_pop   = capture && head_valid;
        fifo_push  = in_valid && in_ready && !bypass_cap;
    end

    assign sh_data = drive_cmd.data;
    assign sh_sc   = drive_cmd.sc;
    assign sh_fn   = drive_cmd.fn;

    always_comb begin
        res_state_d = res_state_q;
        res_data_d  = res_data_q;
        res_c_d     = res_c_q;
        res_z_d     = res_z_q;
        case (res_state_q)
            RES_EMPTY: if (capture) res_state_d = RES_FULL;
            RES_FULL: begin
                if (capture)        res_state_d = RES_FULL;
                else if (res_ready) res_state_d = RES_EMPTY;
            end
            default: res_state_d = RES_EMPTY;
        endcase
        if (capture) begin
            res_data_d = sh_out;
            res_z_d    = sh_z;
            res_c_d    = carry_defined(drive_cmd) ? sh_c : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_state_q <= RES_EMPTY;
            res_data_q  <= '0;
            res_c_q     <= 1'b0;
            res_z_q     <= 1'b0;
        end else begin
            res_state_q <= res_state_d;
            res_data_q  <= res_data_d;
            res_c_q     <= res_c_d;
            res_z_q     <= res_z_d;
        end
    end

    assign res_valid = (res_state_q == RES_FULL);
    assign res_data  = res_data_q;
    assign res_c     = res_c_q;
    assign res_z     = res_z_q;

endmodule

// File: tb/tb_shift_issue_queue.sv
// tb/tb_shift_issue_queue.sv - scoreboard bench for shift_issue_queue with a behavioural shifter
module tb_shift_issue_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_sc;
    logic [1:0] in_fn;
    logic [7:0] sh_data;
    logic [2:0] sh_sc;
    logic [1:0] sh_fn;
    logic [7:0] sh_out;
    logic       sh_c;
    logic       sh_z;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_c;
    logic       res_z;
    logic [2:0] q_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0] sb [$];

    always #5 clk = ~clk;

    shift_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sc(in_sc), .in_fn(in_fn),
        .sh_data(sh_data), .sh_sc(sh_sc), .sh_fn(sh_fn),
        .sh_out(sh_out), .sh_c(sh_c), .sh_z(sh_z),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_c(res_c), .res_z(res_z),
        .q_count(q_count)
    );

    // Shifter stand-in: carry is deliberately 1 where the real unit leaves it undefined.
    logic [15:0] sh_t;
    always_comb begin
        sh_t = '0;
        sh_c = 1'b1;
        case (sh_fn)
            2'b00: begin sh_t = {8'h00, sh_data} << sh_sc; sh_out = sh_t[7:0];
                   if (sh_sc != 0) sh_c = sh_t[8]; end
            2'b01: begin sh_t = {sh_data, 8'h00} >> sh_sc; sh_out = sh_t[15:8];
                   if (sh_sc != 0) sh_c = sh_t[7]; end
            2'b10: begin sh_t = {sh_data, sh_data} << sh_sc; sh_out = sh_t[15:8]; end
            default: begin sh_t = {sh_data, sh_data} >> sh_sc; sh_out = sh_t[7:0]; end
        endcase
        sh_z = (sh_out == 8'h00);
    end

    function automatic logic [9:0] ref_res(input logic [7:0] d, input logic [2:0] s, input logic [1:0] f);
        logic [7:0] o;
        logic       c;
        o = d;
        c = 1'b0;
        for (int i = 0; i < int'(s); i++) begin
            case (f)
                2'b00: begin c = o[7]; o = {o[6:0], 1'b0}; end
                2'b01: begin c = o[0]; o = {1'b0, o[7:1]}; end
                2'b10: o = {o[6:0], o[7]};
                default: o = {o[0], o[7:1]};
            endcase
        end
        if (f[1]) c = 1'b0;
        return {o, c, (o == 8'h00)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'({res_data, res_c, res_z}), 32'h3ff);
            end else begin
                check("result", 32'({res_data, res_c, res_z}), 32'(sb.pop_front()));
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic [2:0] s, input logic [1:0] f, input logic [9:0] exp);
        int w = 0;
        in_valid = 1'b1; in_data = d; in_sc = s; in_fn = f;
        while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
        if (!in_ready) begin
            check("push_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back(exp);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 100) begin @(posedge clk); w++; end
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sc = '0; in_fn = '0; res_ready = 1'b1;
        #12;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_q_count", 32'(q_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_sh_bus", 32'({sh_data, sh_sc, sh_fn}), 32'd0);
        check("rst_res_bits", 32'({res_data, res_c, res_z}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LSL and accept-to-valid latency
        push(8'h92, 3'd1, 2'b00, {8'h24, 1'b1, 1'b0});
`ifdef SHIFT_Q_BYPASS_EN
        check("lat_valid_e0", 32'(res_valid), 32'd1);
`else
        check("lat_valid_e0", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_valid_e1", 32'(res_valid), 32'd1);
`endif
        drain();

        // Hand-computed directed vectors, issued back to back
        push(8'h36, 3'd2, 2'b01, {8'h0D, 1'b1, 1'b0});
        push(8'h36, 3'd5, 2'b11, {8'hB1, 1'b0, 1'b0});
        push(8'h00, 3'd0, 2'b00, {8'h00, 1'b0, 1'b1});
        push(8'h81, 3'd7, 2'b01, {8'h01, 1'b0, 1'b0});
        push(8'h01, 3'd1, 2'b01, {8'h00, 1'b1, 1'b1});
        push(8'hA5, 3'd0, 2'b10, {8'hA5, 1'b0, 1'b0});
        push(8'h81, 3'd1, 2'b10, {8'h03, 1'b0, 1'b0});
        drain();

        // Back-pressure: one held result plus DEPTH queued
        res_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            logic [7:0] d;
            d = 8'(8'h11 * (i + 1));
            push(d, 3'(i + 1), 2'b00, ref_res(d, 3'(i + 1), 2'b00));
        end
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_q_count", 32'(q_count), 32'(DEPTH));
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_data", 32'({res_valid, res_data}), 32'({1'b1, 8'h22}));
        res_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            @(negedge clk);
            check("bp_stream_valid", 32'(res_valid), 32'd1);
        end
        @(negedge clk);
        check("bp_stream_end", 32'(res_valid), 32'd0);
        drain();

        // Simultaneous push and capture with the FIFO half full, wrapping pointers
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(8'(8'h40 + i), 3'd3, 2'b10, ref_res(8'(8'h40 + i), 3'd3, 2'b10));
        check("half_q_count", 32'(q_count), 32'd2);
        res_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH + 2; i++) begin
            logic [7:0] d;
            d = 8'(i * 37 + 5);
            push(d, 3'(i % 8), 2'(i % 4), ref_res(d, 3'(i % 8), 2'(i % 4)));
            check("pushpop_q_count", 32'(q_count), 32'd2);
        end
        drain();

        // Asynchronous reset in the middle of a stalled stream
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(8'hF0, 3'd2, 2'b01, ref_res(8'hF0, 3'd2, 2'b01));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_res_valid", 32'(res_valid), 32'd0);
        check("arst_q_count", 32'(q_count), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_res_data", 32'(res_data), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        push(8'h0F, 3'd4, 2'b00, {8'hF0, 1'b0, 1'b0});
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
